// File: rtl/scaler_pkg.sv
// Shared types and width helpers for the 2:1 video down-scaler.
// Mode and line-parity encodings plus constant functions used to size the datapath.
package scaler_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_H2     = 2'b01,
        MODE_2X2    = 2'b10
    } mode_e;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } parity_e;

    function automatic int hsum_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int vsum_w(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // The reserved encoding 11 behaves as the full 2x2 average.
    function automatic mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'b00:   return MODE_BYPASS;
            2'b01:   return MODE_H2;
            default: return MODE_2X2;
        endcase
    endfunction

endpackage

// File: rtl/image_scaler_2x2_avg_if.sv
// Pixel stream into and out of the scaler; slave is the scaler side, master the source/sink side.
// No backpressure: the sink must take every de_out cycle.
interface image_scaler_2x2_avg_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3
);
    logic                         vs_in;
    logic                         de_in;
    logic [DATA_W*CHANNELS-1:0]   i_pixel;
    logic [1:0]                   mode;
    logic                         de_out;
    logic [DATA_W*CHANNELS-1:0]   o_pixel;
    logic                         line_ovf;

    modport master (
        output vs_in, de_in, i_pixel, mode,
        input  de_out, o_pixel, line_ovf
    );

    modport slave (
        input  vs_in, de_in, i_pixel, mode,
        output de_out, o_pixel, line_ovf
    );
endinterface

// File: rtl/scaler_line_ram.sv
// Simple dual-port line buffer holding horizontal pair sums of the previous line.
// Read data is registered (1 cycle); no reset on the array, no backpressure.
module scaler_line_ram
    import scaler_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int DEPTH = 1024,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/image_scaler_2x2_avg.sv
// Streaming 2:1 scaler (bypass / horizontal 2:1 / 2x2 box average), mode latched at frame start.
// Output registered 1 cycle after the sampled pixel (B pixel for scaled modes); no backpressure.
module image_scaler_2x2_avg
    import scaler_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CHANNELS      = 3,
    parameter int MAX_SRC_WIDTH = 2048,
    parameter int ADDR_W        = 10
) (
    input logic                   pixclk_in,
    input logic                   rst_n,
    image_scaler_2x2_avg_if.slave vid
);

    localparam int PIX_W = DATA_W * CHANNELS;
    localparam int HS_W  = hsum_w(DATA_W);
    localparam int VS_W  = vsum_w(DATA_W);
    localparam int RAM_W = CHANNELS * HS_W;
    localparam int CW    = ADDR_W + 2;
    localparam logic [CW-1:0] COL_MAX = CW'(MAX_SRC_WIDTH);

    logic             vs_d;
    logic             de_d;
    mode_e            mode_r;
    parity_e          parity;
    logic [CW-1:0]    col;
    logic [PIX_W-1:0] a_q;

    logic             vs_rise;
    mode_e            mode_eff;
    parity_e          par_eff;
    logic [CW-1:0]    col_eff;
    logic             in_range;
    logic             pix_a;
    logic             pix_b;
    logic [ADDR_W-1:0] pair_addr;
    logic             wr_en;
    logic             rd_en;
    logic [RAM_W-1:0] hsum;
    logic [RAM_W-1:0] rd_sum;
    logic [PIX_W-1:0] havg;
    logic [PIX_W-1:0] vavg;

    assign vs_rise = vid.vs_in & ~vs_d;

    // A frame restart applies to the pixel arriving on the same cycle.
    always_comb begin
        mode_eff = mode_r;
        par_eff  = parity;
        col_eff  = col;
        if (vs_rise) begin
            mode_eff = norm_mode(vid.mode);
            par_eff  = EVEN;
            col_eff  = '0;
        end
    end

    assign in_range  = col_eff < COL_MAX;
    assign pix_a     = vid.de_in & in_range & ~col_eff[0];
    assign pix_b     = vid.de_in & in_range &  col_eff[0];
    assign pair_addr = col_eff[ADDR_W:1];
    assign wr_en     = pix_b & (mode_eff == MODE_2X2) & (par_eff == EVEN);
    assign rd_en     = pix_a & (mode_eff == MODE_2X2) & (par_eff == ODD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [HS_W-1:0] h;
        assign h = HS_W'(a_q[c*DATA_W +: DATA_W]) + HS_W'(vid.i_pixel[c*DATA_W +: DATA_W]);
        assign hsum[c*HS_W +: HS_W]     = h;
        assign havg[c*DATA_W +: DATA_W] = DATA_W'((h + HS_W'(1)) >> 1);
        assign vavg[c*DATA_W +: DATA_W] =
            DATA_W'((VS_W'(rd_sum[c*HS_W +: HS_W]) + VS_W'(h) + VS_W'(2)) >> 2);
    end

    scaler_line_ram #(
        .WIDTH (RAM_W),
        .DEPTH (MAX_SRC_WIDTH / 2)
    ) u_line_ram (
        .clk     (pixclk_in),
        .wr_en   (wr_en),
        .wr_addr (pair_addr),
        .wr_dat  (hsum),
        .rd_en   (rd_en),
        .rd_addr (pair_addr),
        .rd_dat  (rd_sum)
    );

    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            vs_d         <= 1'b0;
            de_d         <= 1'b0;
            mode_r       <= MODE_BYPASS;
            parity       <= EVEN;
            col          <= '0;
            a_q          <= '0;
            vid.line_ovf <= 1'b0;
            vid.de_out   <= 1'b0;
            vid.o_pixel  <= '0;
        end else begin
            vs_d   <= vid.vs_in;
            de_d   <= vid.de_in;
            mode_r <= mode_eff;
            parity <= par_eff;
            col    <= col_eff;
            if (vs_rise) vid.line_ovf <= 1'b0;
            if (vid.de_in) begin
                if (in_range) col <= col_eff + CW'(1);
                else          vid.line_ovf <= 1'b1;
            end else if (de_d && !vs_rise) begin
                col    <= '0;
                parity <= (parity == EVEN) ? ODD : EVEN;
            end
            if (pix_a) a_q <= vid.i_pixel;
            case (mode_eff)
                MODE_BYPASS: begin
                    vid.de_out  <= vid.de_in;
                    vid.o_pixel <= vid.i_pixel;
                end
                MODE_H2: begin
                    vid.de_out <= pix_b;
                    if (pix_b) vid.o_pixel <= havg;
                end
                default: begin
                    vid.de_out <= pix_b & (par_eff == ODD);
                    if (pix_b && par_eff == ODD) vid.o_pixel <= vavg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_scaler_2x2_avg.sv
// Bench for image_scaler_2x2_avg: directed and random lines against a line-level reference model.
module tb_image_scaler_2x2_avg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    image_scaler_2x2_avg_if #(.DATA_W(8), .CHANNELS(3)) vif ();
    image_scaler_2x2_avg_if #(.DATA_W(8), .CHANNELS(3)) sif ();

    assign sif.vs_in   = vif.vs_in;
    assign sif.de_in   = vif.de_in;
    assign sif.i_pixel = vif.i_pixel;
    assign sif.mode    = vif.mode;

    image_scaler_2x2_avg #(.DATA_W(8), .CHANNELS(3), .MAX_SRC_WIDTH(2048), .ADDR_W(10)) dut (
        .pixclk_in (clk),
        .rst_n     (rst_n),
        .vid       (vif)
    );

    image_scaler_2x2_avg #(.DATA_W(8), .CHANNELS(3), .MAX_SRC_WIDTH(8), .ADDR_W(2)) dut_s (
        .pixclk_in (clk),
        .rst_n     (rst_n),
        .vid       (sif)
    );

    logic [23:0] mq[$];
    int          mcq[$];
    logic [23:0] sq[$];
    logic [23:0] eq[$];
    int          ecq[$];

    always @(negedge clk) begin
        if (vif.de_out === 1'b1) begin
            mq.push_back(vif.o_pixel);
            mcq.push_back(cyc);
        end
        if (sif.de_out === 1'b1) sq.push_back(sif.o_pixel);
    end

    // Reference model: frame mode, line parity and the previous line's pair sums.
    int m_mode = 0;
    int m_par = 0;
    int lb[1024][3];

    function automatic int ch(input logic [23:0] p, input int c);
        return int'((p >> (8 * c)) & 24'hFF);
    endfunction

    task automatic model_line(input logic [23:0] px[$], input int cy[$]);
        logic [23:0] o;
        int s;
        if (m_mode == 0) begin
            for (int i = 0; i < px.size(); i++) begin
                eq.push_back(px[i]);
                ecq.push_back(cy[i] + 1);
            end
        end else begin
            for (int k = 0; 2 * k + 1 < px.size(); k++) begin
                o = '0;
                for (int c = 0; c < 3; c++) begin
                    s = ch(px[2*k], c) + ch(px[2*k+1], c);
                    if (m_mode == 1)      o[8*c +: 8] = 8'((s + 1) / 2);
                    else if (m_par == 0)  lb[k][c] = s;
                    else                  o[8*c +: 8] = 8'((lb[k][c] + s + 2) / 4);
                end
                if (m_mode == 1 || m_par == 1) begin
                    eq.push_back(o);
                    ecq.push_back(cy[2*k+1] + 1);
                end
            end
        end
        m_par ^= 1;
    endtask

    task automatic clear_q();
        mq.delete(); mcq.delete(); sq.delete(); eq.delete(); ecq.delete();
    endtask

    task automatic frame_start(input logic [1:0] m);
        vif.mode  = m;
        vif.vs_in = 1'b1;
        @(posedge clk); #1;
        vif.vs_in = 1'b0;
        @(posedge clk); #1;
        m_mode = (m == 2'd3) ? 2 : int'(m);
        m_par  = 0;
    endtask

    task automatic send_line(input logic [23:0] px[$], input bit vs_first, input logic [1:0] new_mode);
        int cy[$];
        for (int i = 0; i < px.size(); i++) begin
            vif.de_in   = 1'b1;
            vif.i_pixel = px[i];
            vif.vs_in   = vs_first && (i == 0);
            if (vs_first && i == 0) vif.mode = new_mode;
            cy.push_back(cyc);
            @(posedge clk); #1;
        end
        vif.de_in = 1'b0;
        vif.vs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (vs_first) begin
            m_mode = (new_mode == 2'd3) ? 2 : int'(new_mode);
            m_par  = 0;
        end
        model_line(px, cy);
    endtask

    task automatic rand_line(input int w, output logic [23:0] px[$]);
        px.delete();
        for (int i = 0; i < w; i++) px.push_back(24'($urandom));
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total += 3;
        if (vif.de_out !== 1'b0)    begin bad++; $display("FAIL reset_de_out got=%b want=0", vif.de_out); end
        if (vif.o_pixel !== 24'h0)  begin bad++; $display("FAIL reset_o_pixel got=%h want=000000", vif.o_pixel); end
        if (vif.line_ovf !== 1'b0)  begin bad++; $display("FAIL reset_line_ovf got=%b want=0", vif.line_ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        clear_q();
        frame_start(2'd0);
        send_line('{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C}, 1'b0, 2'd0);
        total++;
        if (mq.size() != 4) begin bad++; $display("FAIL bypass_count got=%0d want=4", mq.size()); end
        for (int i = 0; i < eq.size() && i < mq.size(); i++) begin
            total++;
            if (mq[i] !== eq[i] || mcq[i] != ecq[i]) begin
                bad++; $display("FAIL bypass_out[%0d] got=%h@%0d want=%h@%0d", i, mq[i], mcq[i], eq[i], ecq[i]);
            end
        end
    endtask

    task automatic test_h2();
        clear_q();
        frame_start(2'd1);
        send_line('{24'h000000, 24'h010101, 24'hFF00FF, 24'hFE0000}, 1'b0, 2'd0);
        total++;
        if (mq.size() != 2) begin bad++; $display("FAIL h2_count got=%0d want=2", mq.size()); end
        else begin
            total += 2;
            if (mq[0] !== 24'h010101) begin bad++; $display("FAIL h2_round_up got=%h want=010101", mq[0]); end
            if (mq[1] !== 24'hFF0080) begin bad++; $display("FAIL h2_mixed got=%h want=FF0080", mq[1]); end
        end
        for (int i = 0; i < eq.size() && i < mq.size(); i++) begin
            total++;
            if (mq[i] !== eq[i] || mcq[i] != ecq[i]) begin
                bad++; $display("FAIL h2_out[%0d] got=%h@%0d want=%h@%0d", i, mq[i], mcq[i], eq[i], ecq[i]);
            end
        end
    endtask

    task automatic test_2x2();
        clear_q();
        frame_start(2'd2);
        send_line('{24'h101010, 24'h202020}, 1'b0, 2'd0);
        total++;
        if (mq.size() != 0) begin bad++; $display("FAIL avg_even_silent got=%0d want=0", mq.size()); end
        send_line('{24'h303030, 24'h414141}, 1'b0, 2'd0);
        total++;
        if (mq.size() != 1) begin bad++; $display("FAIL avg_count got=%0d want=1", mq.size()); end
        else begin
            total += 2;
            if (mq[0] !== 24'h282828) begin bad++; $display("FAIL avg_value got=%h want=282828", mq[0]); end
            if (mcq[0] != ecq[0]) begin bad++; $display("FAIL avg_latency got=%0d want=%0d", mcq[0], ecq[0]); end
        end
    endtask

    task automatic test_odd_abort();
        logic [23:0] px[$];
        clear_q();
        frame_start(2'd2);
        rand_line(5, px); send_line(px, 1'b0, 2'd0);
        rand_line(5, px); send_line(px, 1'b0, 2'd0);
        rand_line(5, px); send_line(px, 1'b0, 2'd0);
        rand_line(3, px); send_line(px, 1'b0, 2'd0);
        total++;
        if (mq.size() != 3) begin bad++; $display("FAIL odd_abort_count got=%0d want=3", mq.size()); end
        for (int i = 0; i < eq.size() && i < mq.size(); i++) begin
            total++;
            if (mq[i] !== eq[i] || mcq[i] != ecq[i]) begin
                bad++; $display("FAIL odd_abort_out[%0d] got=%h@%0d want=%h@%0d", i, mq[i], mcq[i], eq[i], ecq[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [23:0] px[$];
        logic [23:0] o;
        clear_q();
        frame_start(2'd1);
        total++;
        if (sif.line_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b want=0", sif.line_ovf); end
        rand_line(10, px);
        send_line(px, 1'b0, 2'd0);
        total++;
        if (sq.size() != 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", sq.size()); end
        for (int k = 0; k < 4 && k < sq.size(); k++) begin
            for (int c = 0; c < 3; c++) o[8*c +: 8] = 8'((ch(px[2*k], c) + ch(px[2*k+1], c) + 1) / 2);
            total++;
            if (sq[k] !== o) begin bad++; $display("FAIL ovf_out[%0d] got=%h want=%h", k, sq[k], o); end
        end
        total += 2;
        if (sif.line_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", sif.line_ovf); end
        if (vif.line_ovf !== 1'b0) begin bad++; $display("FAIL ovf_wide_clear got=%b want=0", vif.line_ovf); end
        frame_start(2'd1);
        total++;
        if (sif.line_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", sif.line_ovf); end
    endtask

    task automatic test_mode_change();
        logic [23:0] px[$];
        clear_q();
        frame_start(2'd2);
        rand_line(6, px); send_line(px, 1'b0, 2'd0);
        vif.mode = 2'd0;
        rand_line(6, px); send_line(px, 1'b0, 2'd0);
        total++;
        if (mq.size() != 3) begin bad++; $display("FAIL mode_hold_count got=%0d want=3", mq.size()); end
        frame_start(2'd0);
        rand_line(3, px); send_line(px, 1'b0, 2'd0);
        total++;
        if (mq.size() != 6) begin bad++; $display("FAIL mode_new_count got=%0d want=6", mq.size()); end
        for (int i = 0; i < eq.size() && i < mq.size(); i++) begin
            total++;
            if (mq[i] !== eq[i] || mcq[i] != ecq[i]) begin
                bad++; $display("FAIL mode_out[%0d] got=%h@%0d want=%h@%0d", i, mq[i], mcq[i], eq[i], ecq[i]);
            end
        end
    endtask

    task automatic test_vs_priority();
        logic [23:0] px[$];
        clear_q();
        frame_start(2'd2);
        rand_line(4, px); send_line(px, 1'b0, 2'd0);
        rand_line(4, px); send_line(px, 1'b1, 2'd1);
        total++;
        if (mq.size() != 2) begin bad++; $display("FAIL vs_prio_count got=%0d want=2", mq.size()); end
        for (int i = 0; i < eq.size() && i < mq.size(); i++) begin
            total++;
            if (mq[i] !== eq[i] || mcq[i] != ecq[i]) begin
                bad++; $display("FAIL vs_prio_out[%0d] got=%h@%0d want=%h@%0d", i, mq[i], mcq[i], eq[i], ecq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] px[$];
        int last_w;
        int w;
        int nl;
        clear_q();
        last_w = 1;
        for (int f = 0; f < 8; f++) begin
            frame_start(2'($urandom_range(0, 3)));
            nl = $urandom_range(1, 5);
            for (int l = 0; l < nl; l++) begin
                if (m_par == 1) w = $urandom_range(1, last_w);
                else begin
                    w = $urandom_range(1, 20);
                    last_w = w;
                end
                rand_line(w, px);
                send_line(px, 1'b0, 2'd0);
            end
        end
        total++;
        if (mq.size() != eq.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", mq.size(), eq.size()); end
        for (int i = 0; i < eq.size() && i < mq.size(); i++) begin
            total++;
            if (mq[i] !== eq[i] || mcq[i] != ecq[i]) begin
                bad++; $display("FAIL rand_out[%0d] got=%h@%0d want=%h@%0d", i, mq[i], mcq[i], eq[i], ecq[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        frame_start(2'd0);
        vif.de_in   = 1'b1;
        vif.i_pixel = 24'hABCDEF;
        @(posedge clk); #1;
        total++;
        if (vif.de_out !== 1'b1) begin bad++; $display("FAIL midline_active got=%b want=1", vif.de_out); end
        #1 rst_n = 1'b0;
        #1;
        total += 3;
        if (vif.de_out !== 1'b0)   begin bad++; $display("FAIL midline_rst_de got=%b want=0", vif.de_out); end
        if (vif.o_pixel !== 24'h0) begin bad++; $display("FAIL midline_rst_px got=%h want=000000", vif.o_pixel); end
        if (vif.line_ovf !== 1'b0) begin bad++; $display("FAIL midline_rst_ovf got=%b want=0", vif.line_ovf); end
        vif.de_in = 1'b0;
    endtask

    initial begin
        vif.vs_in   = 1'b0;
        vif.de_in   = 1'b0;
        vif.i_pixel = '0;
        vif.mode    = 2'd0;
        test_reset();
        test_bypass();
        test_h2();
        test_2x2();
        test_odd_abort();
        test_overflow();
        test_mode_change();
        test_vs_priority();
        test_random();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
